core_sequencer: RTL and testbench

- Multi-cycle control unit for the 4-bit core. Replaces the free-running program counter.
- Steps each instruction through FETCH, EXEC and WRITE states. Generates the register-file and flags write strobes.
- Executes jumps, conditional branches and HALT. Exposes run/step/halt control for board-level bring-up.
- Sits between the instruction ROM, the register file/ALU/flags register, and the FPGA control inputs.

---
 rtl/core_sequencer.sv | 163 ++++++++++++++++
 tb/tb_core_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle control unit for the 4-bit core: walks each instruction through
// FETCH/EXEC/WRITE, resolves jumps/branches/HALT and raises the write strobes.
module core_sequencer #(
    parameter int unsigned PC_W  = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic [15:0]      instr_i,
    input  logic             carry_i,
    input  logic             zero_i,
    output logic [PC_W-1:0]  pc_o,
    output logic [15:0]      instr_o,
    output logic             ram_we_o,
    output logic             flags_we_o,
    output logic [2:0]       state_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_WRITE  = 3'd3,
        S_HALTED = 3'd4
    } state_e;

    localparam logic [OP_W-1:0] SUB_JMP  = 4'h1;
    localparam logic [OP_W-1:0] SUB_JZ   = 4'h2;
    localparam logic [OP_W-1:0] SUB_JC   = 4'h3;
    localparam logic [OP_W-1:0] SUB_HALT = 4'hF;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               run_mode_q, run_mode_d;
    logic               taken_q, taken_d;
    logic               ram_we_q, ram_we_d;
    logic               flags_we_q, flags_we_d;
    logic               halted_q, halted_d;

    logic [OP_W-1:0]    op;
    logic [OP_W-1:0]    sub;
    logic               is_alu;
    logic               is_halt;
    logic               branch_taken;

    // Instruction decode from the instruction register
    always_comb begin
        op           = instr_q[15:12];
        sub          = instr_q[11:8];
        is_alu       = (op != '0);
        is_halt      = !is_alu && (sub == SUB_HALT);
        branch_taken = 1'b0;
        if (!is_alu) begin
            case (sub)
                SUB_JMP: branch_taken = 1'b1;
                SUB_JZ:  branch_taken = zero_i;
                SUB_JC:  branch_taken = carry_i;
                default: branch_taken = 1'b0;
            endcase
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        retired_d  = retired_q;
        run_mode_d = run_mode_q;
        taken_d    = taken_q;
        ram_we_d   = 1'b0;
        flags_we_d = 1'b0;
        halted_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!halt_req && run) begin
                    run_mode_d = 1'b1;
                    state_d    = S_FETCH;
                end else if (!halt_req && step) begin
                    run_mode_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_d = instr_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_halt) begin
                    retired_d = retired_q + CNT_W'(1);
                    halted_d  = 1'b1;
                    state_d   = S_HALTED;
                end else begin
                    // Flags are sampled here, before this instruction's own write lands
                    taken_d    = branch_taken;
                    ram_we_d   = is_alu;
                    flags_we_d = is_alu;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                pc_d      = taken_q ? instr_q[PC_W-1:0] : pc_q + PC_W'(1);
                retired_d = retired_q + CNT_W'(1);
                if (run_mode_q && !halt_req) begin
                    state_d = S_FETCH;
                end else begin
                    run_mode_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_HALTED: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            retired_q  <= '0;
            run_mode_q <= 1'b0;
            taken_q    <= 1'b0;
            ram_we_q   <= 1'b0;
            flags_we_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            retired_q  <= retired_d;
            run_mode_q <= run_mode_d;
            taken_q    <= taken_d;
            ram_we_q   <= ram_we_d;
            flags_we_q <= flags_we_d;
            halted_q   <= halted_d;
        end
    end

    assign pc_o       = pc_q;
    assign instr_o    = instr_q;
    assign ram_we_o   = ram_we_q;
    assign flags_we_o = flags_we_q;
    assign state_o    = state_q;
    assign halted_o   = halted_q;
    assign retired_o  = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer; a per-instruction scoreboard is filled
// from a reference model when stimulus is launched and drained on retirement.
module tb_core_sequencer;

    logic        clock;
    logic        rst_n;
    logic        run;
    logic        step;
    logic        halt_req;
    logic [15:0] instr_i;
    logic        carry_i;
    logic        zero_i;
    logic [2:0]  pc_o;
    logic [15:0] instr_o;
    logic        ram_we_o;
    logic        flags_we_o;
    logic [2:0]  state_o;
    logic        halted_o;
    logic [7:0]  retired_o;

    logic [15:0] rom [8];

    typedef struct {
        logic [2:0] pc;
        logic [7:0] ret;
        int         we;
        logic       halted;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] m_pc;
    logic [7:0] m_ret;
    int         n_chk;
    int         n_err;
    int         we_cnt;
    bit         mon_en;
    logic [2:0] prev_state;

    core_sequencer #(.PC_W(3), .CNT_W(8)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .run        (run),
        .step       (step),
        .halt_req   (halt_req),
        .instr_i    (instr_i),
        .carry_i    (carry_i),
        .zero_i     (zero_i),
        .pc_o       (pc_o),
        .instr_o    (instr_o),
        .ram_we_o   (ram_we_o),
        .flags_we_o (flags_we_o),
        .state_o    (state_o),
        .halted_o   (halted_o),
        .retired_o  (retired_o)
    );

    assign instr_i = rom[pc_o];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: instruction-level effect of the next n instructions
    task automatic predict(input int n);
        logic [15:0] ins;
        logic        taken;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            ins = rom[m_pc];
            if (ins[15:12] == 4'h0 && ins[11:8] == 4'hF) begin
                m_ret++;
                e.pc = m_pc; e.ret = m_ret; e.we = 0; e.halted = 1'b1;
                sb.push_back(e);
                break;
            end
            taken = (ins[15:12] == 4'h0) &&
                    ((ins[11:8] == 4'h1) ||
                     (ins[11:8] == 4'h2 && zero_i) ||
                     (ins[11:8] == 4'h3 && carry_i));
            m_pc  = taken ? ins[2:0] : m_pc + 3'd1;
            m_ret++;
            e.pc = m_pc; e.ret = m_ret; e.we = (ins[15:12] != 4'h0) ? 1 : 0; e.halted = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_pc  = '0;
        m_ret = '0;
    endtask

    // Run exactly two instructions from pc 0, stopping via halt_req
    task automatic run_two(input logic [2:0] exp_pc, input string tag);
        predict(2);
        run = 1'b1;
        tick();
        repeat (3) tick();
        halt_req = 1'b1;
        run      = 1'b0;
        repeat (3) tick();
        halt_req = 1'b0;
        chk({tag, "_state"}, 32'(state_o), 32'd0);
        chk({tag, "_pc"}, 32'(pc_o), 32'(exp_pc));
    endtask

    // Retirement monitor: pops one expectation per completed instruction
    always @(negedge clock) begin
        if (mon_en) begin
            if (ram_we_o) we_cnt++;
            chk("strobe_pair", 32'(flags_we_o), 32'(ram_we_o));
            if ((prev_state == 3'd3 && state_o != 3'd3) ||
                (prev_state == 3'd2 && state_o == 3'd4)) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_retire", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_pc", 32'(pc_o), 32'(e.pc));
                    chk("sb_retired", 32'(retired_o), 32'(e.ret));
                    chk("sb_we_count", 32'(we_cnt), 32'(e.we));
                    chk("sb_halted", 32'(halted_o), 32'(e.halted));
                end
                we_cnt = 0;
            end
        end
        prev_state = state_o;
    end

    initial begin
        n_chk = 0; n_err = 0; we_cnt = 0; mon_en = 1'b0; prev_state = 3'd0;
        rst_n = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        carry_i = 1'b0; zero_i = 1'b0;
        for (int i = 0; i < 8; i++) rom[i] = 16'h1000 | 16'(i);

        // Reset values
        tick();
        do_reset();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_pc", 32'(pc_o), 32'd0);
        chk("rst_instr", 32'(instr_o), 32'd0);
        chk("rst_retired", 32'(retired_o), 32'd0);
        chk("rst_ram_we", 32'(ram_we_o), 32'd0);
        chk("rst_halted", 32'(halted_o), 32'd0);
        mon_en = 1'b1;

        // Continuous run over eight ALU instructions plus one wrapped
        predict(9);
        run = 1'b1;
        tick();
        for (int k = 0; k < 24; k++) begin
            chk("run_state_seq", 32'(state_o), 32'(1 + (k % 3)));
            chk("run_we_every_3rd", 32'(ram_we_o), (k % 3 == 2) ? 32'd1 : 32'd0);
            tick();
        end
        chk("run_retired_8", 32'(retired_o), 32'd8);
        chk("run_pc_wrap", 32'(pc_o), 32'd0);
        halt_req = 1'b1;
        repeat (3) tick();
        chk("run_stop_state", 32'(state_o), 32'd0);
        chk("run_stop_pc", 32'(pc_o), 32'd1);
        repeat (3) tick();
        chk("halt_hold_idle", 32'(state_o), 32'd0);
        run = 1'b0; halt_req = 1'b0;

        // Single steps: pc 1 -> 2, then pc 2 -> 3 with timing checks
        predict(1);
        step = 1'b1; tick(); step = 1'b0;
        repeat (3) tick();
        chk("step1_pc", 32'(pc_o), 32'd2);
        predict(1);
        step = 1'b1; tick(); step = 1'b0;
        chk("step2_fetch", 32'(state_o), 32'd1);
        tick();
        chk("step2_exec", 32'(state_o), 32'd2);
        tick();
        chk("step2_write", 32'(state_o), 32'd3);
        chk("step2_we", 32'(ram_we_o), 32'd1);
        tick();
        chk("step2_idle", 32'(state_o), 32'd0);
        chk("step2_pc", 32'(pc_o), 32'd3);
        chk("step2_retired", 32'(retired_o), 32'd11);

        // halt_req raised during EXEC of the instruction at pc 4
        predict(2);
        run = 1'b1;
        repeat (4) tick();
        chk("hr_pc4", 32'(pc_o), 32'd4);
        tick();
        chk("hr_exec", 32'(state_o), 32'd2);
        halt_req = 1'b1;
        tick();
        chk("hr_we", 32'(ram_we_o), 32'd1);
        tick();
        chk("hr_idle", 32'(state_o), 32'd0);
        chk("hr_pc5", 32'(pc_o), 32'd5);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("hr_no_fetch", 32'(state_o), 32'd0);
        end
        run = 1'b0; halt_req = 1'b0;

        // Branches at pc 1, flags left by the ALU op at pc 0
        rom[0] = 16'h1234;
        rom[1] = 16'h0206;
        zero_i = 1'b1; carry_i = 1'b0;
        do_reset();
        run_two(3'd6, "jz_taken");
        zero_i = 1'b0;
        do_reset();
        run_two(3'd2, "jz_not_taken");
        rom[1] = 16'h0300;
        carry_i = 1'b1;
        do_reset();
        run_two(3'd0, "jc_taken");
        carry_i = 1'b0;

        // HALT at pc 3 is absorbing until reset
        for (int i = 0; i < 8; i++) rom[i] = 16'h2000 | 16'(i);
        rom[3] = 16'h0F00;
        do_reset();
        predict(4);
        run = 1'b1;
        tick();
        repeat (9) tick();
        chk("hlt_fetch", 32'(state_o), 32'd1);
        chk("hlt_fetch_pc", 32'(pc_o), 32'd3);
        run = 1'b0;
        repeat (2) tick();
        chk("hlt_state", 32'(state_o), 32'd4);
        chk("hlt_halted", 32'(halted_o), 32'd1);
        for (int k = 0; k < 20; k++) begin
            run = 1'(k % 2); step = 1'(~k % 2); halt_req = 1'(k % 3 == 0);
            tick();
            chk("hlt_absorb", 32'(state_o), 32'd4);
        end
        chk("hlt_pc_hold", 32'(pc_o), 32'd3);
        chk("hlt_retired", 32'(retired_o), 32'd4);
        do_reset();
        run = 1'b0; step = 1'b0; halt_req = 1'b0;
        chk("hlt_rst_state", 32'(state_o), 32'd0);
        chk("hlt_rst_pc", 32'(pc_o), 32'd0);
        chk("hlt_rst_retired", 32'(retired_o), 32'd0);
        chk("hlt_rst_halted", 32'(halted_o), 32'd0);

        // Reset in the middle of WRITE suppresses the following strobe
        mon_en = 1'b0;
        rom[0] = 16'h5000;
        step = 1'b1; tick(); step = 1'b0;
        repeat (2) tick();
        chk("mid_write_state", 32'(state_o), 32'd3);
        chk("mid_write_we", 32'(ram_we_o), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_we", 32'(ram_we_o), 32'd0);
        chk("mid_rst_fwe", 32'(flags_we_o), 32'd0);
        chk("mid_rst_state", 32'(state_o), 32'd0);
        chk("mid_rst_pc", 32'(pc_o), 32'd0);
        chk("mid_rst_instr", 32'(instr_o), 32'd0);
        chk("mid_rst_retired", 32'(retired_o), 32'd0);
        tick();
        chk("post_rst_we", 32'(ram_we_o), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
